// File: rtl/aq_mmu_sysmap_cfg.sv
// System-map region table for the MMU.
// Software writes go into a shadow table. A commit checks that the shadow table
// is monotonic and then copies it into the active table in one cycle. Lookups
// use the active table and answer one cycle after they are accepted.
module aq_mmu_sysmap_cfg #(
    parameter int                   ADDR_WIDTH = 28,
    parameter int                   FLG_WIDTH  = 5,
    parameter int                   ENTRY_NUM  = 8,
    parameter logic [FLG_WIDTH-1:0] DFLT_FLG   = 5'b10011
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  regs_sysmap_wr_vld,
    input  logic [2:0]            regs_sysmap_wr_idx,
    input  logic                  regs_sysmap_wr_sel,
    input  logic [ADDR_WIDTH-1:0] regs_sysmap_wr_data,
    output logic                  sysmap_regs_wr_rdy,
    input  logic                  regs_sysmap_commit,
    output logic                  sysmap_regs_commit_done,
    output logic                  sysmap_regs_cfg_err,
    input  logic                  mmu_sysmap_req_vld,
    input  logic [ADDR_WIDTH-1:0] mmu_sysmap_pa,
    output logic                  sysmap_mmu_req_rdy,
    output logic                  sysmap_mmu_rsp_vld,
    output logic [FLG_WIDTH-1:0]  sysmap_mmu_flg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] sh_addr  [ENTRY_NUM];
    logic [FLG_WIDTH-1:0]  sh_flg   [ENTRY_NUM];
    logic [ADDR_WIDTH-1:0] act_addr [ENTRY_NUM];
    logic [FLG_WIDTH-1:0]  act_flg  [ENTRY_NUM];

    logic [ADDR_WIDTH-1:0] pa_q;
    logic                  rsp_vld_q;
    logic                  done_q;
    logic                  cfg_err_q;

    logic                  wr_acc;
    logic                  req_acc;
    logic                  sh_mono;
    logic [ENTRY_NUM-1:0]  hit;
    logic [FLG_WIDTH-1:0]  hit_flg;

    assign sysmap_regs_wr_rdy      = (state == IDLE);
    assign sysmap_mmu_req_rdy      = (state == IDLE);
    assign wr_acc                  = regs_sysmap_wr_vld && sysmap_regs_wr_rdy;
    assign req_acc                 = mmu_sysmap_req_vld && sysmap_mmu_req_rdy;
    assign sysmap_mmu_rsp_vld      = rsp_vld_q;
    assign sysmap_regs_commit_done = done_q;
    assign sysmap_regs_cfg_err     = cfg_err_q;

    // Commit state register
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. DRAIN lasts one cycle because no lookups are accepted while it is active.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (regs_sysmap_commit) begin
                    state_nxt = rsp_vld_q ? DRAIN : COMMIT;
                end
            end
            DRAIN:   state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shadow table is only written by accepted configuration writes
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
                sh_addr[i] <= '0;
                sh_flg[i]  <= DFLT_FLG;
            end
        end else if (wr_acc) begin
            if (regs_sysmap_wr_sel) begin
                sh_flg[regs_sysmap_wr_idx] <= regs_sysmap_wr_data[FLG_WIDTH-1:0];
            end else begin
                sh_addr[regs_sysmap_wr_idx] <= regs_sysmap_wr_data;
            end
        end
    end

    // The shadow table can be committed only when its upper bounds never decrease
    always_comb begin
        sh_mono = 1'b1;
        for (int unsigned i = 1; i < ENTRY_NUM; i++) begin
            if (sh_addr[i] < sh_addr[i-1]) begin
                sh_mono = 1'b0;
            end
        end
    end

    // Active table and error flag. Both change only in the COMMIT state.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
                act_addr[i] <= '0;
                act_flg[i]  <= DFLT_FLG;
            end
            cfg_err_q <= 1'b0;
        end else if (state == COMMIT) begin
            if (sh_mono) begin
                for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
                    act_addr[i] <= sh_addr[i];
                    act_flg[i]  <= sh_flg[i];
                end
                cfg_err_q <= 1'b0;
            end else begin
                cfg_err_q <= 1'b1;
            end
        end
    end

    // Commit-done pulse in the first IDLE cycle after COMMIT
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state == COMMIT);
        end
    end

    // Lookup stage: registers the accepted PA and the response valid
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            pa_q      <= '0;
            rsp_vld_q <= 1'b0;
        end else begin
            rsp_vld_q <= req_acc;
            if (req_acc) begin
                pa_q <= mmu_sysmap_pa;
            end
        end
    end

    // Region compare: each entry covers [addr(x-1), addr(x)). Entry 0 starts at zero.
    always_comb begin
        hit    = '0;
        hit[0] = (pa_q < act_addr[0]);
        for (int unsigned i = 1; i < ENTRY_NUM; i++) begin
            hit[i] = (act_addr[i-1] <= pa_q) && (pa_q < act_addr[i]);
        end
    end

    // One-hot flag mux. No hit, or more than one hit, falls back to the default flags.
    always_comb begin
        hit_flg = '0;
        for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
            if (hit[i]) begin
                hit_flg = hit_flg | act_flg[i];
            end
        end
        sysmap_mmu_flg = $onehot(hit) ? hit_flg : DFLT_FLG;
    end

endmodule

// File: tb/tb_aq_mmu_sysmap_cfg.sv
// Directed testbench for aq_mmu_sysmap_cfg with hand-computed expected values.
module tb_aq_mmu_sysmap_cfg;

    localparam logic [4:0] DFLT = 5'b10011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_vld = 1'b0;
    logic [2:0]  wr_idx = '0;
    logic        wr_sel = 1'b0;
    logic [27:0] wr_data = '0;
    logic        wr_rdy;
    logic        commit = 1'b0;
    logic        done;
    logic        cfg_err;
    logic        req_vld = 1'b0;
    logic [27:0] pa = '0;
    logic        req_rdy;
    logic        rsp_vld;
    logic [4:0]  flg;

    int n_cmp = 0;
    int n_bad = 0;

    logic exp_rdy [0:7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    aq_mmu_sysmap_cfg #(
        .ADDR_WIDTH (28),
        .FLG_WIDTH  (5),
        .ENTRY_NUM  (8),
        .DFLT_FLG   (5'b10011)
    ) dut (
        .forever_cpuclk          (clk),
        .cpurst_b                (rst_n),
        .regs_sysmap_wr_vld      (wr_vld),
        .regs_sysmap_wr_idx      (wr_idx),
        .regs_sysmap_wr_sel      (wr_sel),
        .regs_sysmap_wr_data     (wr_data),
        .sysmap_regs_wr_rdy      (wr_rdy),
        .regs_sysmap_commit      (commit),
        .sysmap_regs_commit_done (done),
        .sysmap_regs_cfg_err     (cfg_err),
        .mmu_sysmap_req_vld      (req_vld),
        .mmu_sysmap_pa           (pa),
        .sysmap_mmu_req_rdy      (req_rdy),
        .sysmap_mmu_rsp_vld      (rsp_vld),
        .sysmap_mmu_flg          (flg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] idx, input logic sel, input logic [27:0] data);
        wr_vld  = 1'b1;
        wr_idx  = idx;
        wr_sel  = sel;
        wr_data = data;
        step();
        wr_vld  = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [27:0] addr, input logic [4:0] exp);
        req_vld = 1'b1;
        pa      = addr;
        step();
        req_vld = 1'b0;
        chk({tag, "_vld"}, 32'(rsp_vld), 32'd1);
        chk({tag, "_flg"}, 32'(flg), 32'(exp));
    endtask

    // Pulse commit (clearing any write presented alongside it) and wait for done with a bound
    task automatic commit_run(input string tag, input int exp_lat);
        int cyc;
        commit = 1'b1;
        step();
        commit = 1'b0;
        wr_vld = 1'b0;
        cyc = 1;
        while (!done && cyc < 10) begin
            step();
            cyc++;
        end
        chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_rdy"},  32'(wr_rdy),  32'd1);
        chk({tag, "_req_rdy"}, 32'(req_rdy), 32'd1);
        chk({tag, "_rsp_vld"}, 32'(rsp_vld), 32'd0);
        chk({tag, "_flg"},     32'(flg),     32'(DFLT));
        chk({tag, "_done"},    32'(done),    32'd0);
        chk({tag, "_err"},     32'(cfg_err), 32'd0);
    endtask

    initial begin
        // Reset
        step();
        step();
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        step();

        // Lookups against the reset table
        lookup("rst_pa0", 28'h0000000, DFLT);
        lookup("rst_pa8", 28'h8000000, DFLT);
        step();

        // Program eight regions of 64K pages each
        for (int i = 0; i < 8; i++) begin
            do_write(3'(i), 1'b0, 28'(28'h0010000 * (i + 1)));
            do_write(3'(i), 1'b1, 28'(i + 1));
        end
        commit = 1'b1;
        step();
        commit = 1'b0;
        chk("c1_req_rdy", 32'(req_rdy), 32'd0);
        chk("c1_done_early", 32'(done), 32'd0);
        step();
        chk("c1_done", 32'(done), 32'd1);
        chk("c1_err", 32'(cfg_err), 32'd0);
        chk("c1_req_rdy_back", 32'(req_rdy), 32'd1);
        step();
        chk("c1_done_pulse", 32'(done), 32'd0);

        lookup("lk_ffff",  28'h000FFFF, 5'd1);
        lookup("lk_10000", 28'h0010000, 5'd2);
        lookup("lk_30000", 28'h0030000, 5'd4);
        lookup("lk_7ffff", 28'h007FFFF, 5'd8);
        lookup("lk_80000", 28'h0080000, DFLT);
        step();

        // Back-to-back lookups with a commit in cycle 3; shadow flg0 changed to 20
        do_write(3'd0, 1'b1, 28'd20);
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) begin
                chk($sformatf("b2b_rsp_vld%0d", c), 32'(rsp_vld), 32'(exp_rdy[c-1]));
                if (exp_rdy[c-1]) begin
                    chk($sformatf("b2b_flg%0d", c), 32'(flg), (c - 1 <= 3) ? 32'd1 : 32'd20);
                end
            end
            if (c < 8) begin
                req_vld = 1'b1;
                pa      = 28'h0000005;
                commit  = (c == 3);
                chk($sformatf("b2b_rdy%0d", c), 32'(req_rdy), 32'(exp_rdy[c]));
                chk($sformatf("b2b_done%0d", c), 32'(done), (c == 6) ? 32'd1 : 32'd0);
                step();
            end
            req_vld = 1'b0;
            commit  = 1'b0;
        end
        step();

        // Non-monotonic table is rejected; a valid commit clears the error
        do_write(3'd3, 1'b0, 28'h0001000);
        commit_run("bad", 2);
        chk("bad_err", 32'(cfg_err), 32'd1);
        lookup("bad_lk", 28'h0035000, 5'd4);
        do_write(3'd3, 1'b0, 28'h0040000);
        commit_run("fix", 2);
        chk("fix_err", 32'(cfg_err), 32'd0);

        // Writes during DRAIN and COMMIT are dropped
        req_vld = 1'b1;
        pa      = 28'h0055555;
        step();
        pa      = 28'h0065555;
        commit  = 1'b1;
        chk("drp_rdy_c1", 32'(req_rdy), 32'd1);
        step();
        req_vld = 1'b0;
        commit  = 1'b0;
        chk("drp_rsp_vld", 32'(rsp_vld), 32'd1);
        chk("drp_rsp_flg", 32'(flg), 32'd7);
        chk("drp_drain_wr_rdy", 32'(wr_rdy), 32'd0);
        wr_vld  = 1'b1;
        wr_idx  = 3'd5;
        wr_sel  = 1'b1;
        wr_data = 28'd25;
        step();
        chk("drp_commit_wr_rdy", 32'(wr_rdy), 32'd0);
        wr_idx  = 3'd6;
        wr_data = 28'd26;
        step();
        wr_vld  = 1'b0;
        chk("drp_done", 32'(done), 32'd1);
        commit_run("drp_re", 2);
        lookup("drp_lk5", 28'h0055555, 5'd6);
        lookup("drp_lk6", 28'h0065555, 5'd7);
        step();

        // Write and commit in the same IDLE cycle
        wr_vld  = 1'b1;
        wr_idx  = 3'd7;
        wr_sel  = 1'b1;
        wr_data = 28'd30;
        commit_run("same", 2);
        lookup("same_lk7", 28'h0075555, 5'd30);

        // Top boundary: addr7 = FFFFFFF with pa = FFFFFFF returns the default
        do_write(3'd7, 1'b0, 28'hFFFFFFF);
        commit_run("top", 2);
        lookup("top_lk", 28'hFFFFFFF, DFLT);
        lookup("top_lk_below", 28'hFFFFFFE, 5'd30);
        step();

        // Set cfg_err, then reset while in DRAIN
        do_write(3'd3, 1'b0, 28'h0001000);
        commit_run("pre_rst", 2);
        chk("pre_rst_err", 32'(cfg_err), 32'd1);
        req_vld = 1'b1;
        pa      = 28'h0001000;
        step();
        commit  = 1'b1;
        step();
        req_vld = 1'b0;
        commit  = 1'b0;
        chk("rst2_in_drain", 32'(req_rdy), 32'd0);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst2");
        step();
        rst_n = 1'b1;
        step();
        lookup("rst2_lk", 28'h0015555, DFLT);
        lookup("rst2_lk0", 28'h0000000, DFLT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
